key_event_gen: RTL and testbench
================================

KEY_EVENT_GEN -- requirements
Module: key_event_gen

Parameters
REQ-001 The block SHALL define parameter N_KEYS, default 4, as the number of push-buttons handled.
REQ-002 The block SHALL define parameter DEB_CYC, default 1_000_000, as debounce stability time in clocks (20 ms at 50 MHz).
REQ-003 The block SHALL define parameter LONG_CYC, default 50_000_000, as the hold time in clocks for a long press (1 s).
REQ-004 The block SHALL define parameter REP_CYC, default 10_000_000, as the auto-repeat period in clocks after a long press (200 ms).
REQ-005 The block SHALL define parameter REPEAT_EN, default 1, where 1 enables auto-repeat and 0 disables it.

Interface
REQ-006 CLOCK_50  in  1  single system clock; all logic on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 KEY  in  N_KEYS  raw push-buttons, low = pressed, asynchronous to CLOCK_50.
REQ-009 key_en  in  N_KEYS  per-key enable; 0 forces that key's FSM to IDLE and suppresses its events.
REQ-010 held  out  N_KEYS  debounced pressed level per key.
REQ-011 short_pulse  out  N_KEYS  1-cycle pulse on debounced release of a press shorter than LONG_CYC.
REQ-012 long_pulse  out  N_KEYS  1-cycle pulse when hold reaches LONG_CYC.
REQ-013 repeat_pulse  out  N_KEYS  1-cycle pulse every REP_CYC while still held after long_pulse.
REQ-014 event_valid  out  1  1-cycle pulse when any key emits an event in that cycle.
REQ-015 event_key  out  clog2(N_KEYS) (min 1)  index of the reporting key.
REQ-016 event_type  out  2  event code: 01 = short, 10 = long, 11 = repeat.

Function
REQ-017 Each KEY bit SHALL pass a 2-flop synchroniser; key_s[i] = inverted second-stage output (1 = pressed).
REQ-018 Each key SHALL have an independent FSM with states IDLE, DEB_P, PRESSED, LONG, DEB_R, plus a debounce counter, a hold counter and a long_flag.
REQ-019 IDLE: key_s=1 -> DEB_P with dcnt=0.
REQ-020 DEB_P: key_s=0 -> IDLE; dcnt==DEB_CYC-1 with key_s=1 -> PRESSED, held=1, hcnt=0, long_flag=0; otherwise dcnt++.
REQ-021 PRESSED: key_s=0 -> DEB_R with dcnt=0; hcnt==LONG_CYC-1 -> LONG, long_pulse=1 for one cycle, long_flag=1, hcnt=0; otherwise hcnt++.
REQ-022 LONG: key_s=0 -> DEB_R with dcnt=0; REPEAT_EN=1 and hcnt==REP_CYC-1 -> repeat_pulse=1 for one cycle, hcnt=0; otherwise hcnt++ (saturating when REPEAT_EN=0).
REQ-023 DEB_R: key_s=1 -> return to PRESSED if long_flag=0, else LONG, hcnt unchanged; dcnt==DEB_CYC-1 with key_s=0 -> IDLE, held=0, short_pulse=1 for one cycle if long_flag=0; otherwise dcnt++; hcnt frozen throughout.
REQ-024 All pulse and held outputs SHALL be registered, with no combinational path from KEY.
REQ-025 Latency: held rises on the (DEB_CYC+3)th clock edge counting the first edge that samples KEY low; it falls, and short_pulse fires, on the (DEB_CYC+3)th edge after KEY goes high.
REQ-026 long_pulse SHALL fire exactly LONG_CYC edges after held rises; each repeat_pulse SHALL follow the previous long or repeat pulse by exactly REP_CYC edges.
REQ-027 A released press SHALL produce exactly one of: nothing (bounce shorter than DEB_CYC), short_pulse, or long_pulse (+ repeats); short and long SHALL never both fire for one press.
REQ-028 Simultaneous events on several keys SHALL all appear on their per-key outputs; event_key/event_type SHALL report the lowest index only.
REQ-029 key_en[i] deasserted mid-press SHALL return key i to IDLE next cycle, drop held[i], and emit no pulse; re-enable while pressed SHALL restart at DEB_P.
REQ-030 Counter widths SHALL be clog2(max(DEB_CYC, LONG_CYC, REP_CYC)) bits, with no wrap inside any state.

Reset
REQ-031 rst_n=0 SHALL immediately force all FSMs to IDLE, clear all counters and long_flag, set synchroniser flops to 1 (released), and drive all outputs to 0.
REQ-032 A key held during reset release SHALL go through a full DEB_P before held asserts; no pulse SHALL appear during or as a direct result of reset.

Verification (DEB_CYC=4, LONG_CYC=20, REP_CYC=5, N_KEYS=4)
REQ-033 KEY[0] low for 12 edges, then high -> held[0] rises at edge 7; short_pulse[0] is 1 cycle, 7 edges after release; event_key=0, event_type=01.
REQ-034 KEY[1] low for 60 edges -> long_pulse[1] 20 edges after held rises, repeat_pulse[1] at +5, +10, ...; no short_pulse on release.
REQ-035 KEY[2] glitch low for 3 edges -> no held, no pulses; 2-edge high bounce mid-press -> press remains a single press and the hold count is not reset.
REQ-036 KEY[0] and KEY[3] pressed and released identically -> both short_pulse bits in the same cycle; event_key=0.
REQ-037 rst_n pulsed low during LONG repeat -> all outputs 0 at once; after release with KEY still low, held returns after a full debounce and no short_pulse fires.
REQ-038 key_en[1] cleared mid-press -> held[1]=0 next cycle and no events from key 1.

Source files
------------

// File: rtl/key_event_gen.sv
// Debounced push-button event generator: per-key short / long / auto-repeat
// pulses plus a lowest-index-wins event report.

module key_event_lane #(
  parameter int DEB_CYC   = 1_000_000,
  parameter int LONG_CYC  = 50_000_000,
  parameter int REP_CYC   = 10_000_000,
  parameter int REPEAT_EN = 1,
  parameter int CW        = 26
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  input  logic i_en,
  output logic o_held,
  output logic o_short,
  output logic o_long,
  output logic o_rep,
  output logic o_short_nxt,
  output logic o_long_nxt,
  output logic o_rep_nxt
);
  typedef enum logic [2:0] {IDLE, DEB_P, PRESSED, LONG, DEB_R} state_t;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REP_CYC - 1);

  logic [1:0]    r_sync;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_dcnt, w_dcnt_nxt;
  logic [CW-1:0] r_hcnt, w_hcnt_nxt;
  logic          r_lflag, w_lflag_nxt;
  logic          r_held, w_held_nxt;
  logic          r_short, r_long, r_rep;
  logic          w_key_s;

  // Raw KEY is active-low; reset value 1 means "released".
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_key};
  end

  assign w_key_s = ~r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_dcnt  <= '0;
      r_hcnt  <= '0;
      r_lflag <= 1'b0;
      r_held  <= 1'b0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_rep   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_lflag <= w_lflag_nxt;
      r_held  <= w_held_nxt;
      r_short <= o_short_nxt;
      r_long  <= o_long_nxt;
      r_rep   <= o_rep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_hcnt_nxt  = r_hcnt;
    w_lflag_nxt = r_lflag;
    w_held_nxt  = r_held;
    o_short_nxt = 1'b0;
    o_long_nxt  = 1'b0;
    o_rep_nxt   = 1'b0;
    if (!i_en) begin
      w_state_nxt = IDLE;
      w_dcnt_nxt  = '0;
      w_hcnt_nxt  = '0;
      w_lflag_nxt = 1'b0;
      w_held_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_key_s) begin
          w_state_nxt = DEB_P;
          w_dcnt_nxt  = '0;
        end
        DEB_P: begin
          if (!w_key_s) w_state_nxt = IDLE;
          else if (r_dcnt == DEB_LAST) begin
            w_state_nxt = PRESSED;
            w_held_nxt  = 1'b1;
            w_hcnt_nxt  = '0;
            w_lflag_nxt = 1'b0;
          end else w_dcnt_nxt = r_dcnt + 1'b1;
        end
        PRESSED: begin
          if (!w_key_s) begin
            w_state_nxt = DEB_R;
            w_dcnt_nxt  = '0;
          end else if (r_hcnt == LONG_LAST) begin
            w_state_nxt = LONG;
            o_long_nxt  = 1'b1;
            w_lflag_nxt = 1'b1;
            w_hcnt_nxt  = '0;
          end else w_hcnt_nxt = r_hcnt + 1'b1;
        end
        LONG: begin
          if (!w_key_s) begin
            w_state_nxt = DEB_R;
            w_dcnt_nxt  = '0;
          end else if (REPEAT_EN != 0) begin
            if (r_hcnt == REP_LAST) begin
              o_rep_nxt  = 1'b1;
              w_hcnt_nxt = '0;
            end else w_hcnt_nxt = r_hcnt + 1'b1;
          end else if (r_hcnt != '1) w_hcnt_nxt = r_hcnt + 1'b1;
        end
        // Hold count is frozen here so a release bounce does not eat hold time.
        DEB_R: begin
          if (w_key_s) w_state_nxt = r_lflag ? LONG : PRESSED;
          else if (r_dcnt == DEB_LAST) begin
            w_state_nxt = IDLE;
            w_held_nxt  = 1'b0;
            o_short_nxt = ~r_lflag;
          end else w_dcnt_nxt = r_dcnt + 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign o_held  = r_held;
  assign o_short = r_short;
  assign o_long  = r_long;
  assign o_rep   = r_rep;
endmodule

module key_event_gen #(
  parameter int N_KEYS    = 4,
  parameter int DEB_CYC   = 1_000_000,
  parameter int LONG_CYC  = 50_000_000,
  parameter int REP_CYC   = 10_000_000,
  parameter int REPEAT_EN = 1,
  localparam int KW = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] KEY,
  input  logic [N_KEYS-1:0] key_en,
  output logic [N_KEYS-1:0] held,
  output logic [N_KEYS-1:0] short_pulse,
  output logic [N_KEYS-1:0] long_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic              event_valid,
  output logic [KW-1:0]     event_key,
  output logic [1:0]        event_type
);
  localparam int MAXC = (DEB_CYC > LONG_CYC) ?
                        ((DEB_CYC > REP_CYC) ? DEB_CYC : REP_CYC) :
                        ((LONG_CYC > REP_CYC) ? LONG_CYC : REP_CYC);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;

  logic [N_KEYS-1:0] w_short_nxt, w_long_nxt, w_rep_nxt;
  logic              w_ev_valid;
  logic [KW-1:0]     w_ev_key;
  logic [1:0]        w_ev_type;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_event_lane #(
      .DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .REP_CYC(REP_CYC),
      .REPEAT_EN(REPEAT_EN), .CW(CW)
    ) u_lane (
      .i_clk      (CLOCK_50),
      .i_rst_n    (rst_n),
      .i_key      (KEY[g]),
      .i_en       (key_en[g]),
      .o_held     (held[g]),
      .o_short    (short_pulse[g]),
      .o_long     (long_pulse[g]),
      .o_rep      (repeat_pulse[g]),
      .o_short_nxt(w_short_nxt[g]),
      .o_long_nxt (w_long_nxt[g]),
      .o_rep_nxt  (w_rep_nxt[g])
    );
  end

  // Scan high-to-low so the lowest-index reporting key wins.
  always_comb begin
    w_ev_valid = 1'b0;
    w_ev_key   = '0;
    w_ev_type  = 2'b00;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (w_short_nxt[i] | w_long_nxt[i] | w_rep_nxt[i]) begin
        w_ev_valid = 1'b1;
        w_ev_key   = KW'(i);
        w_ev_type  = w_short_nxt[i] ? 2'b01 : (w_long_nxt[i] ? 2'b10 : 2'b11);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      event_valid <= 1'b0;
      event_key   <= '0;
      event_type  <= 2'b00;
    end else begin
      event_valid <= w_ev_valid;
      event_key   <= w_ev_key;
      event_type  <= w_ev_type;
    end
  end
endmodule

// File: tb/tb_key_event_gen.sv
// Directed + random bench for key_event_gen; reference model tracks debounced
// level, disagreement run length and accumulated hold time per key.

module tb_key_event_gen;
  localparam int NK  = 4;
  localparam int DEB = 4;
  localparam int LNG = 20;
  localparam int REP = 5;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n;
  logic [NK-1:0] KEY, key_en;
  logic [NK-1:0] held, short_pulse, long_pulse, repeat_pulse;
  logic          event_valid;
  logic [1:0]    event_key, event_type;

  key_event_gen #(
    .N_KEYS(NK), .DEB_CYC(DEB), .LONG_CYC(LNG), .REP_CYC(REP), .REPEAT_EN(1)
  ) dut (
    .CLOCK_50(CLOCK_50), .rst_n(rst_n), .KEY(KEY), .key_en(key_en),
    .held(held), .short_pulse(short_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .event_valid(event_valid),
    .event_key(event_key), .event_type(event_type)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int errors = 0;
  int checks = 0;

  logic [NK-1:0] m_p1, m_p2, m_lvl, m_longed;
  int            m_run[NK];
  int            m_t[NK];
  logic [NK-1:0] e_short, e_long, e_rep;
  logic          e_valid;
  logic [1:0]    e_key, e_type;

  int   trk_w, g, held_at, short_at, long_at, rep_at;
  int   n_rise, n_short, n_long, n_rep, n_both, n_ev;
  logic prev_held;
  logic [1:0] ev_key_seen, ev_type_seen;

  logic [NK-1:0] rnd_k, rnd_en;
  int            rnd_rem[NK];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_p1 = '1; m_p2 = '1; m_lvl = '0; m_longed = '0;
    for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_t[i] = 0; end
    e_short = '0; e_long = '0; e_rep = '0;
    e_valid = 1'b0; e_key = 2'b00; e_type = 2'b00;
  endtask

  // A level change is accepted after DEB+1 consecutive disagreeing samples;
  // hold time accrues only on settled pressed samples.
  task automatic model_edge(input logic [NK-1:0] k, input logic [NK-1:0] en);
    logic ks;
    e_short = '0; e_long = '0; e_rep = '0;
    for (int i = 0; i < NK; i++) begin
      ks = ~m_p2[i];
      if (!en[i]) begin
        m_lvl[i] = 1'b0; m_run[i] = 0; m_t[i] = 0; m_longed[i] = 1'b0;
      end else if (ks != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB + 1) begin
          m_lvl[i] = ks;
          m_run[i] = 0;
          if (ks) begin m_t[i] = 0; m_longed[i] = 1'b0; end
          else if (!m_longed[i]) e_short[i] = 1'b1;
        end
      end else begin
        if (m_lvl[i] && m_run[i] == 0) begin
          m_t[i]++;
          if (m_t[i] == LNG) begin e_long[i] = 1'b1; m_longed[i] = 1'b1; end
          else if (m_t[i] > LNG && (m_t[i] - LNG) % REP == 0) e_rep[i] = 1'b1;
        end
        m_run[i] = 0;
      end
    end
    m_p2 = m_p1;
    m_p1 = k;
    e_valid = 1'b0; e_key = 2'b00; e_type = 2'b00;
    for (int i = NK - 1; i >= 0; i--) begin
      if (e_short[i] | e_long[i] | e_rep[i]) begin
        e_valid = 1'b1;
        e_key   = 2'(i);
        e_type  = e_short[i] ? 2'b01 : (e_long[i] ? 2'b10 : 2'b11);
      end
    end
  endtask

  task automatic check_outputs();
    chk("held",   32'(held),         32'(m_lvl));
    chk("short",  32'(short_pulse),  32'(e_short));
    chk("long",   32'(long_pulse),   32'(e_long));
    chk("repeat", 32'(repeat_pulse), 32'(e_rep));
    chk("ev_valid", 32'(event_valid), 32'(e_valid));
    if (e_valid) begin
      chk("ev_key",  32'(event_key),  32'(e_key));
      chk("ev_type", 32'(event_type), 32'(e_type));
    end
  endtask

  task automatic trk_start(input int w);
    trk_w = w; g = 0;
    held_at = -1; short_at = -1; long_at = -1; rep_at = -1;
    n_rise = 0; n_short = 0; n_long = 0; n_rep = 0; n_both = 0; n_ev = 0;
    prev_held = held[w];
    ev_key_seen = 2'b11; ev_type_seen = 2'b00;
  endtask

  task automatic step(input logic [NK-1:0] k, input logic [NK-1:0] en);
    KEY = k; key_en = en;
    @(posedge CLOCK_50);
    model_edge(k, en);
    #1;
    check_outputs();
    g++;
    if (held[trk_w] && !prev_held) begin
      n_rise++;
      if (held_at < 0) held_at = g;
    end
    prev_held = held[trk_w];
    if (short_pulse[trk_w]) begin
      n_short++;
      if (short_at < 0) begin
        short_at = g; ev_key_seen = event_key; ev_type_seen = event_type;
      end
    end
    if (long_pulse[trk_w]) begin n_long++; if (long_at < 0) long_at = g; end
    if (repeat_pulse[trk_w]) begin n_rep++; if (rep_at < 0) rep_at = g; end
    if (short_pulse == 4'b1001) n_both++;
    if (event_valid && event_key == 2'(trk_w)) n_ev++;
  endtask

  task automatic run_seg(input logic [NK-1:0] k, input logic [NK-1:0] en, input int n);
    for (int j = 0; j < n; j++) step(k, en);
  endtask

  initial begin
    rst_n = 1'b1; KEY = '1; key_en = '1;
    model_reset();
    trk_w = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_held", 32'(held), 32'd0);
    check_outputs();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_pulses", 32'({short_pulse, long_pulse, repeat_pulse, event_valid}), 32'd0);
    rst_n = 1'b1;

    // Short press on key 0
    trk_start(0);
    run_seg(4'b1110, '1, 12);
    chk("s_held_at", 32'(held_at), 32'd7);
    run_seg('1, '1, 15);
    chk("s_short_lat", 32'(short_at - 12), 32'd7);
    chk("s_short_n", 32'(n_short), 32'd1);
    chk("s_long_n", 32'(n_long), 32'd0);
    chk("s_ev_key", 32'(ev_key_seen), 32'd0);
    chk("s_ev_type", 32'(ev_type_seen), 32'd1);

    // Long press with repeats on key 1
    trk_start(1);
    run_seg(4'b1101, '1, 60);
    chk("l_long_lat", 32'(long_at - held_at), 32'd20);
    chk("l_rep_lat", 32'(rep_at - long_at), 32'd5);
    chk("l_rep_n", 32'(n_rep), 32'd6);
    run_seg('1, '1, 15);
    chk("l_short_n", 32'(n_short), 32'd0);
    chk("l_long_n", 32'(n_long), 32'd1);

    // Glitch then mid-press bounce on key 2
    trk_start(2);
    run_seg(4'b1011, '1, 3);
    run_seg('1, '1, 15);
    chk("g_rise", 32'(n_rise), 32'd0);
    chk("g_pulses", 32'(n_short + n_long + n_rep), 32'd0);
    trk_start(2);
    run_seg(4'b1011, '1, 20);
    run_seg('1, '1, 2);
    run_seg(4'b1011, '1, 18);
    chk("b_rise", 32'(n_rise), 32'd1);
    chk("b_long_at", 32'(long_at), 32'd30);
    run_seg('1, '1, 15);
    chk("b_short_n", 32'(n_short), 32'd0);

    // Keys 0 and 3 together
    trk_start(0);
    run_seg(4'b0110, '1, 10);
    run_seg('1, '1, 15);
    chk("d_both", 32'(n_both), 32'd1);
    chk("d_ev_key", 32'(ev_key_seen), 32'd0);

    // Reset during repeat on key 1
    trk_start(1);
    run_seg(4'b1101, '1, 40);
    rst_n = 1'b0;
    #1;
    chk("r_outs", 32'({held, short_pulse, long_pulse, repeat_pulse,
                       event_valid, event_key, event_type}), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge CLOCK_50);
      #1;
      check_outputs();
    end
    rst_n = 1'b1;
    trk_start(1);
    run_seg(4'b1101, '1, 10);
    chk("r_held_at", 32'(held_at), 32'd7);
    chk("r_pulses", 32'(n_short + n_long + n_rep), 32'd0);
    run_seg('1, '1, 15);

    // Enable drop mid-press on key 1
    trk_start(1);
    run_seg(4'b1101, '1, 12);
    run_seg(4'b1101, 4'b1101, 1);
    chk("e_drop", 32'(held[1]), 32'd0);
    run_seg(4'b1101, 4'b1101, 10);
    run_seg('1, 4'b1101, 10);
    chk("e_no_ev", 32'(n_ev), 32'd0);
    chk("e_no_pulse", 32'(n_short + n_long + n_rep), 32'd0);
    trk_start(1);
    run_seg(4'b1101, 4'b1101, 3);
    run_seg(4'b1101, '1, 10);
    chk("e_rearm", 32'(n_rise), 32'd1);
    run_seg('1, '1, 15);

    // Random per-key segments with occasional enable toggles
    rnd_k = '1; rnd_en = '1;
    for (int i = 0; i < NK; i++) rnd_rem[i] = int'($urandom_range(1, 30));
    trk_start(0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NK; i++) begin
        if (rnd_rem[i] == 0) begin
          rnd_k[i] = ~rnd_k[i];
          rnd_rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                   : int'($urandom_range(5, 45));
        end else rnd_rem[i]--;
      end
      if ($urandom_range(0, 199) == 0) rnd_en[$urandom_range(0, NK - 1)] ^= 1'b1;
      step(rnd_k, rnd_en);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
